// File: rtl/rf_wb_sched_pkg.sv
// Shared widths and writeback-source selection for the RF write scheduler.
package rf_wb_sched_pkg;

  localparam int W_RD  = 4;
  localparam int WORD  = 32;
  localparam int N_REG = 1 << W_RD;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_HOLD = 2'd2,
    SRC_EX   = 2'd3
  } wb_src_e;

  // Loads are never stalled, so they always win; a parked EX result beats a fresh one.
  function automatic wb_src_e pick_src(input logic mem_v, input logic hold_v, input logic ex_acc);
    wb_src_e src;
    src = SRC_NONE;
    if (mem_v) begin
      src = SRC_MEM;
    end else if (hold_v) begin
      src = SRC_HOLD;
    end else if (ex_acc) begin
      src = SRC_EX;
    end
    return src;
  endfunction

endpackage

// File: rtl/rf_wb_sched_scoreboard.sv
// Per-register reservation bits: set on reserve, cleared one edge after the RF write,
// combinational queries, sticky protocol-error detection. Updates take effect next edge.
module rf_wb_sched_scoreboard
  import rf_wb_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set_v_i,
  input  logic [W_RD-1:0] set_name_i,
  input  logic            clr_v_i,
  input  logic [W_RD-1:0] clr_name_i,
  input  logic [W_RD-1:0] q_rd_name_i,
  input  logic [W_RD-1:0] q_rs_name_i,
  output logic            q_rd_o,
  output logic            q_rs_o,
  input  logic            ex_v_i,
  input  logic            ex_acc_i,
  input  logic [W_RD-1:0] ex_name_i,
  input  logic            mem_v_i,
  input  logic [W_RD-1:0] mem_name_i,
  output logic            empty_o,
  output logic            err_o
);

  logic [N_REG-1:0] r_bits;
  logic             r_err;
  logic [N_REG-1:0] w_bits_nxt;
  logic             w_err_evt;

  assign q_rd_o  = r_bits[q_rd_name_i];
  assign q_rs_o  = r_bits[q_rs_name_i];
  assign empty_o = (r_bits == '0);
  assign err_o   = r_err;

  // Clear applied before set so a same-edge set of the same register survives.
  always_comb begin
    w_bits_nxt = r_bits;
    if (clr_v_i) begin
      w_bits_nxt[clr_name_i] = 1'b0;
    end
    if (set_v_i) begin
      w_bits_nxt[set_name_i] = 1'b1;
    end
  end

  assign w_err_evt = (set_v_i  &  r_bits[set_name_i])
                   | (ex_acc_i & ~r_bits[ex_name_i])
                   | (mem_v_i  & ~r_bits[mem_name_i])
                   | (ex_v_i & mem_v_i & (ex_name_i == mem_name_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bits <= '0;
      r_err  <= 1'b0;
    end else begin
      r_bits <= w_bits_nxt;
      r_err  <= r_err | w_err_evt;
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Arbitrates EX and MEM writebacks onto one registered RF write port (1-cycle latency).
// MEM is never stalled; an EX loser parks in a 1-entry hold buffer and EX stalls while it is full.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [W_RD-1:0] rd_name_i,
  input  logic [W_RD-1:0] rs_name_i,
  input  logic            rd_reserve_i,
  output logic            rd_reserved_o,
  output logic            rs_reserved_o,
  input  logic            ex_wb_v_i,
  input  logic [W_RD-1:0] ex_wb_name_i,
  input  logic [WORD-1:0] ex_wb_data_i,
  output logic            ex_stall_o,
  input  logic            mem_wb_v_i,
  input  logic [W_RD-1:0] mem_wb_name_i,
  input  logic [WORD-1:0] mem_wb_data_i,
  output logic            rf_we_o,
  output logic [W_RD-1:0] rf_wa_o,
  output logic [WORD-1:0] rf_wd_o,
  output logic            idle_o,
  output logic            err_o
);

  logic            r_hold_v;
  logic [W_RD-1:0] r_hold_name;
  logic [WORD-1:0] r_hold_data;
  logic            r_rf_we;
  logic [W_RD-1:0] r_rf_wa;
  logic [WORD-1:0] r_rf_wd;

  logic            w_ex_acc;
  logic            w_sb_empty;
  wb_src_e         w_src;

  assign ex_stall_o = r_hold_v;
  assign w_ex_acc   = ex_wb_v_i & ~r_hold_v;
  assign w_src      = pick_src(mem_wb_v_i, r_hold_v, w_ex_acc);

  assign rf_we_o = r_rf_we;
  assign rf_wa_o = r_rf_wa;
  assign rf_wd_o = r_rf_wd;
  assign idle_o  = w_sb_empty & ~r_hold_v;

  // The clear trails the write by one edge, so a cleared bit means the RF already holds the data.
  rf_wb_sched_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_v_i     (rd_reserve_i),
    .set_name_i  (rd_name_i),
    .clr_v_i     (r_rf_we),
    .clr_name_i  (r_rf_wa),
    .q_rd_name_i (rd_name_i),
    .q_rs_name_i (rs_name_i),
    .q_rd_o      (rd_reserved_o),
    .q_rs_o      (rs_reserved_o),
    .ex_v_i      (ex_wb_v_i),
    .ex_acc_i    (w_ex_acc),
    .ex_name_i   (ex_wb_name_i),
    .mem_v_i     (mem_wb_v_i),
    .mem_name_i  (mem_wb_name_i),
    .empty_o     (w_sb_empty),
    .err_o       (err_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_v    <= 1'b0;
      r_hold_name <= '0;
      r_hold_data <= '0;
      r_rf_we     <= 1'b0;
      r_rf_wa     <= '0;
      r_rf_wd     <= '0;
    end else begin
      case (w_src)
        SRC_MEM: begin
          r_rf_we <= 1'b1;
          r_rf_wa <= mem_wb_name_i;
          r_rf_wd <= mem_wb_data_i;
          // Acceptance implies the hold buffer was empty, so nothing is overwritten.
          if (w_ex_acc) begin
            r_hold_v    <= 1'b1;
            r_hold_name <= ex_wb_name_i;
            r_hold_data <= ex_wb_data_i;
          end
        end
        SRC_HOLD: begin
          r_rf_we  <= 1'b1;
          r_rf_wa  <= r_hold_name;
          r_rf_wd  <= r_hold_data;
          r_hold_v <= 1'b0;
        end
        SRC_EX: begin
          r_rf_we <= 1'b1;
          r_rf_wa <= ex_wb_name_i;
          r_rf_wd <= ex_wb_data_i;
        end
        default: begin
          r_rf_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Table-driven directed vectors, hand sequences for hold/stall and reset corners,
// then randomized traffic checked against a queue-based reference model.
module tb_rf_wb_sched;
  import rf_wb_sched_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [W_RD-1:0] rd_name_i, rs_name_i;
  logic            rd_reserve_i;
  logic            rd_reserved_o, rs_reserved_o;
  logic            ex_wb_v_i;
  logic [W_RD-1:0] ex_wb_name_i;
  logic [WORD-1:0] ex_wb_data_i;
  logic            ex_stall_o;
  logic            mem_wb_v_i;
  logic [W_RD-1:0] mem_wb_name_i;
  logic [WORD-1:0] mem_wb_data_i;
  logic            rf_we_o;
  logic [W_RD-1:0] rf_wa_o;
  logic [WORD-1:0] rf_wd_o;
  logic            idle_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk(clk), .rst(rst_n),
    .rd_name_i(rd_name_i), .rs_name_i(rs_name_i), .rd_reserve_i(rd_reserve_i),
    .rd_reserved_o(rd_reserved_o), .rs_reserved_o(rs_reserved_o),
    .ex_wb_v_i(ex_wb_v_i), .ex_wb_name_i(ex_wb_name_i), .ex_wb_data_i(ex_wb_data_i),
    .ex_stall_o(ex_stall_o),
    .mem_wb_v_i(mem_wb_v_i), .mem_wb_name_i(mem_wb_name_i), .mem_wb_data_i(mem_wb_data_i),
    .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  typedef struct {
    logic        res;
    logic [3:0]  rd, rs;
    logic        exv;
    logic [3:0]  exn;
    logic [31:0] exd;
    logic        memv;
    logic [3:0]  memn;
    logic [31:0] memd;
    logic        e_rd, e_rs, e_stall, e_we;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_idle, e_err;
  } vec_t;

  typedef struct {
    logic [3:0]  n;
    logic [31:0] d;
  } wb_t;

  vec_t tbl[13];

  // Reference model state
  bit [15:0]   m_res;
  wb_t         m_hold[$];
  logic        m_we;
  logic [3:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_rd, input logic e_rs,
                           input logic e_stall, input logic e_we, input logic [3:0] e_wa,
                           input logic [31:0] e_wd, input logic e_idle, input logic e_err);
    chk({tag, ".rd_res"}, {31'd0, rd_reserved_o}, {31'd0, e_rd});
    chk({tag, ".rs_res"}, {31'd0, rs_reserved_o}, {31'd0, e_rs});
    chk({tag, ".stall"},  {31'd0, ex_stall_o},    {31'd0, e_stall});
    chk({tag, ".we"},     {31'd0, rf_we_o},       {31'd0, e_we});
    chk({tag, ".wa"},     {28'd0, rf_wa_o},       {28'd0, e_wa});
    chk({tag, ".wd"},     rf_wd_o,                e_wd);
    chk({tag, ".idle"},   {31'd0, idle_o},        {31'd0, e_idle});
    chk({tag, ".err"},    {31'd0, err_o},         {31'd0, e_err});
  endtask

  task automatic set_in(input logic res, input logic [3:0] rd, input logic [3:0] rs,
                        input logic exv, input logic [3:0] exn, input logic [31:0] exd,
                        input logic memv, input logic [3:0] memn, input logic [31:0] memd);
    rd_reserve_i  = res;  rd_name_i = rd;  rs_name_i = rs;
    ex_wb_v_i     = exv;  ex_wb_name_i = exn;  ex_wb_data_i = exd;
    mem_wb_v_i    = memv; mem_wb_name_i = memn; mem_wb_data_i = memd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic res, input logic [3:0] rd, input logic [3:0] rs,
                              input logic exv, input logic [3:0] exn, input logic [31:0] exd,
                              input logic memv, input logic [3:0] memn, input logic [31:0] memd,
                              input logic e_rd, input logic e_rs, input logic e_stall,
                              input logic e_we, input logic [3:0] e_wa, input logic [31:0] e_wd,
                              input logic e_idle, input logic e_err);
    vec_t v;
    v.res = res; v.rd = rd; v.rs = rs; v.exv = exv; v.exn = exn; v.exd = exd;
    v.memv = memv; v.memn = memn; v.memd = memd;
    v.e_rd = e_rd; v.e_rs = e_rs; v.e_stall = e_stall; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_idle = e_idle; v.e_err = e_err;
    return v;
  endfunction

  function automatic logic [3:0] pick_name();
    int cand[$];
    for (int k = 0; k < 16; k++) if (m_res[k]) cand.push_back(k);
    if (cand.size() != 0 && $urandom_range(7, 0) != 0)
      return 4'(cand[$urandom_range(cand.size() - 1, 0)]);
    return 4'($urandom_range(15, 0));
  endfunction

  task automatic model_reset();
    m_res = '0; m_hold.delete(); m_we = 0; m_wa = 0; m_wd = 0; m_err = 0;
  endtask

  // Apply the scheduling rules to the current inputs; state becomes what the next edge produces.
  task automatic model_step();
    bit  ex_acc;
    wb_t e;
    ex_acc = ex_wb_v_i && (m_hold.size() == 0);
    if (rd_reserve_i && m_res[rd_name_i])                    m_err = 1;
    if (ex_acc && !m_res[ex_wb_name_i])                      m_err = 1;
    if (mem_wb_v_i && !m_res[mem_wb_name_i])                 m_err = 1;
    if (ex_wb_v_i && mem_wb_v_i && ex_wb_name_i == mem_wb_name_i) m_err = 1;
    if (m_we) m_res[m_wa] = 1'b0;
    if (rd_reserve_i) m_res[rd_name_i] = 1'b1;
    if (mem_wb_v_i) begin
      m_we = 1; m_wa = mem_wb_name_i; m_wd = mem_wb_data_i;
      if (ex_acc) begin
        e.n = ex_wb_name_i; e.d = ex_wb_data_i;
        m_hold.push_back(e);
      end
    end else if (m_hold.size() != 0) begin
      e = m_hold.pop_front();
      m_we = 1; m_wa = e.n; m_wd = e.d;
    end else if (ex_acc) begin
      m_we = 1; m_wa = ex_wb_name_i; m_wd = ex_wb_data_i;
    end else begin
      m_we = 0;
    end
  endtask

  initial begin
    int rsv[7];
    rsv[0] = 6; rsv[1] = 5; rsv[2] = 8; rsv[3] = 9; rsv[4] = 10; rsv[5] = 11; rsv[6] = 12;

    //          res rd rs exv exn exd      memv memn memd | rd rs st we wa wd       idle err
    tbl[0]  = mk(0, 3, 3, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0,    1, 0);
    tbl[1]  = mk(1, 3, 3, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0,    1, 0);
    tbl[2]  = mk(0, 3, 3, 1, 3, 32'h1234,  0, 0, 32'h0,    1, 1, 0, 0, 0, 32'h0,    0, 0);
    tbl[3]  = mk(0, 3, 3, 0, 0, 32'h0,     0, 0, 32'h0,    1, 1, 0, 1, 3, 32'h1234, 0, 0);
    tbl[4]  = mk(1, 1, 3, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 0, 3, 32'h1234, 1, 0);
    tbl[5]  = mk(1, 2, 1, 0, 0, 32'h0,     0, 0, 32'h0,    0, 1, 0, 0, 3, 32'h1234, 0, 0);
    tbl[6]  = mk(0, 1, 2, 1, 2, 32'hBB,    1, 1, 32'hAA,   1, 1, 0, 0, 3, 32'h1234, 0, 0);
    tbl[7]  = mk(0, 1, 2, 0, 0, 32'h0,     0, 0, 32'h0,    1, 1, 1, 1, 1, 32'hAA,   0, 0);
    tbl[8]  = mk(0, 1, 2, 0, 0, 32'h0,     0, 0, 32'h0,    0, 1, 0, 1, 2, 32'hBB,   0, 0);
    tbl[9]  = mk(0, 1, 2, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 0, 2, 32'hBB,   1, 0);
    tbl[10] = mk(0, 7, 7, 1, 7, 32'h77,    0, 0, 32'h0,    0, 0, 0, 0, 2, 32'hBB,   1, 0);
    tbl[11] = mk(0, 7, 7, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 1, 7, 32'h77,   1, 1);
    tbl[12] = mk(0, 7, 7, 0, 0, 32'h0,     0, 0, 32'h0,    0, 0, 0, 0, 7, 32'h77,   1, 1);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].res, tbl[i].rd, tbl[i].rs, tbl[i].exv, tbl[i].exn, tbl[i].exd,
             tbl[i].memv, tbl[i].memn, tbl[i].memd);
      #1;
      check_all($sformatf("row%0d", i), tbl[i].e_rd, tbl[i].e_rs, tbl[i].e_stall, tbl[i].e_we,
                tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_idle, tbl[i].e_err);
      next_cycle();
    end

    // Hold full while MEM streams for four more cycles; EX r5 waits behind it.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(1, 4'(rsv[i]), 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
    end
    set_in(0, 0, 0, 1, 6, 32'h60, 1, 8, 32'h80);
    #1 chk("storm.accept_stall", {31'd0, ex_stall_o}, 32'd0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 1, 5, 32'h50, 1, 4'(9 + i), 32'h90 + i);
      #1;
      chk($sformatf("storm%0d.stall", i), {31'd0, ex_stall_o}, 32'd1);
      chk($sformatf("storm%0d.wa", i), {28'd0, rf_wa_o}, 32'(8 + i));
      next_cycle();
    end
    set_in(0, 0, 0, 1, 5, 32'h50, 0, 0, 0);
    #1;
    chk("drain.stall", {31'd0, ex_stall_o}, 32'd1);
    chk("drain.wa", {28'd0, rf_wa_o}, 32'd12);
    next_cycle();
    #1;
    chk("held.stall", {31'd0, ex_stall_o}, 32'd0);
    chk("held.we", {31'd0, rf_we_o}, 32'd1);
    chk("held.wa", {28'd0, rf_wa_o}, 32'd6);
    chk("held.wd", rf_wd_o, 32'h60);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("r5.wa", {28'd0, rf_wa_o}, 32'd5);
    chk("r5.wd", rf_wd_o, 32'h50);
    next_cycle();
    next_cycle();
    chk("storm.idle", {31'd0, idle_o}, 32'd1);
    chk("storm.err", {31'd0, err_o}, 32'd0);

    // Reset with the hold buffer full, r4 reserved and the error flag set.
    set_in(1, 4, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    set_in(1, 4, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    set_in(1, 13, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    set_in(1, 14, 0, 0, 0, 0, 0, 0, 0); next_cycle();
    set_in(0, 4, 0, 1, 14, 32'hE, 1, 13, 32'hD); next_cycle();
    set_in(0, 4, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("prerst.stall", {31'd0, ex_stall_o}, 32'd1);
    chk("prerst.err", {31'd0, err_o}, 32'd1);
    chk("prerst.rd4", {31'd0, rd_reserved_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.we", {31'd0, rf_we_o}, 32'd0);
    chk("rst.stall", {31'd0, ex_stall_o}, 32'd0);
    chk("rst.rd4", {31'd0, rd_reserved_o}, 32'd0);
    chk("rst.err", {31'd0, err_o}, 32'd0);
    chk("rst.idle", {31'd0, idle_o}, 32'd1);
    do_reset();

    // Randomized traffic against the reference model, with periodic mid-run resets.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      logic       res;
      logic [3:0] rd;
      rd  = 4'($urandom_range(15, 0));
      res = ($urandom_range(3, 0) == 0);
      if (res && m_res[rd] && $urandom_range(7, 0) != 0) res = 0;
      set_in(res, rd, 4'($urandom_range(15, 0)),
             ($urandom_range(1, 0) == 0), pick_name(), $urandom,
             ($urandom_range(2, 0) == 0), pick_name(), $urandom);
      #1;
      check_all($sformatf("rnd%0d", i), m_res[rd_name_i], m_res[rs_name_i],
                (m_hold.size() != 0), m_we, m_wa, m_wd,
                (m_res == '0) && (m_hold.size() == 0), m_err);
      model_step();
      next_cycle();
      if (i % 150 == 149) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
